// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter.
// RR_LOCK_EN (optional) adds a lock input that holds the grant across acks.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  localparam int ARB_N_DEFAULT = 8;

endpackage

// File: rtl/rr_pick.sv
// Circular priority pick: first set req bit at or after ptr, wrapping.
// Produces both a one-hot vector and its binary index.
module rr_pick #(
  parameter  int N     = 8,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [PTR_W-1:0] pick_idx
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      // N is a power of two, so the add wraps for free
      idx = ptr + PTR_W'(i);
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with a registered one-hot grant, held until ack.
// RR_LOCK_EN adds a lock input: an ack with lock=1 keeps the grant and pointer.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter  int N     = ARB_N_DEFAULT,
  localparam int PTR_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ack,
`ifdef RR_LOCK_EN
  input  logic         lock,
`endif
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  arb_state_t       state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] idx_q;
  logic [N-1:0]     grant_q;
  logic             valid_q;

  logic             in_grant;
  logic             advance;
  logic [N-1:0]     pick_req;
  logic [PTR_W-1:0] pick_ptr;
  logic [N-1:0]     pick;
  logic [PTR_W-1:0] pick_idx;

`ifdef RR_LOCK_EN
  assign advance = ack & ~lock;
`else
  assign advance = ack;
`endif

  assign in_grant = (state_q == ARB_GRANT);
  assign ptr_d    = idx_q + PTR_W'(1);

  // After an ack the current winner is masked so it cannot win twice in a row
  assign pick_req = in_grant ? (req & ~grant_q) : req;
  assign pick_ptr = in_grant ? ptr_d : ptr_q;

  rr_pick #(.N(N)) u_pick (
    .req      (pick_req),
    .ptr      (pick_ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (|req) begin
            grant_q <= pick;
            idx_q   <= pick_idx;
            valid_q <= 1'b1;
            state_q <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (advance) begin
            ptr_q <= ptr_d;
            if (|pick) begin
              grant_q <= pick;
              idx_q   <= pick_idx;
            end else begin
              grant_q <= '0;
              valid_q <= 1'b0;
              state_q <= ARB_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: index-level reference model checked every cycle,
// plus directed literal expectations.
module tb_rr_arbiter8;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         ack;
  logic         lock;
  logic [N-1:0] grant;
  logic         grant_valid;

  int passed;
  int total;

  rr_arbiter8 #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .ack         (ack),
`ifdef RR_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: winner index (-1 when idle) and round-robin pointer
  int mg;
  int mptr;

  function automatic int pick_m(input logic [N-1:0] r,
                                input int p, input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic logic lock_now();
`ifdef RR_LOCK_EN
    return lock;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mg   = -1;
      mptr = 0;
    end else if (mg < 0) begin
      mg = pick_m(req, mptr, -1);
    end else if (ack && !lock_now()) begin
      mptr = (mg + 1) % N;
      mg   = pick_m(req, mptr, mg);
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Every-cycle comparison against the model, away from the clock edge
  always @(negedge clk) begin
    logic [N-1:0] eg;
    eg = (mg < 0) ? '0 : (N'(1) << mg);
    chk("model_grant", grant, eg);
    chk("model_valid", {{(N-1){1'b0}}, grant_valid},
        {{(N-1){1'b0}}, (mg >= 0)});
    chk("invariant", {{(N-1){1'b0}},
        ($onehot0(grant) && (grant_valid == |grant))},
        {{(N-1){1'b0}}, 1'b1});
  end

  task automatic cyc(input logic [N-1:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clk);
    #2;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    mg     = -1;
    mptr   = 0;
    rst_n  = 1'b0;
    req    = 8'hFF;
    ack    = 1'b0;
    lock   = 1'b0;

    // 1. reset holds outputs low despite requests
    repeat (2) @(posedge clk);
    #2;
    chk("reset_grant", grant, 8'h00);
    chk("reset_valid", {7'b0, grant_valid}, 8'h00);
    rst_n = 1'b1;
    cyc(8'hFF, 1'b0);
    chk("first_grant", grant, 8'h01);

    // 3. full rotation with ack every cycle, no bubble
    for (int k = 0; k < 8; k++) begin
      logic [N-1:0] e;
      e = N'(1) << ((k + 1) % 8);
      cyc(8'hFF, 1'b1);
      chk("rotation", grant, e);
    end

    // 4. wrap and fairness: bit 0 just served, ptr=1
    cyc(8'h81, 1'b1);
    chk("wrap_to_7", grant, 8'h80);
    cyc(8'h81, 1'b1);
    chk("wrap_to_0", grant, 8'h01);
    cyc(8'h00, 1'b1);
    chk("drain_idle", grant, 8'h00);

    // ack while idle is ignored
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);
    chk("idle_ack", grant, 8'h00);

    // 2. single request held, then ack with the lone requester masked
    cyc(8'h04, 1'b0);
    chk("single_grant", grant, 8'h04);
    for (int k = 0; k < 5; k++) begin
      cyc(8'h04, 1'b0);
      chk("single_hold", grant, 8'h04);
    end
    cyc(8'h04, 1'b1);
    chk("single_ack", grant, 8'h00);
    cyc(8'h04, 1'b0);
    chk("single_regrant", grant, 8'h04);
    cyc(8'h00, 1'b1);
    chk("single_done", grant, 8'h00);

    // 5. request drop does not withdraw the grant
    cyc(8'h08, 1'b0);
    chk("drop_grant", grant, 8'h08);
    for (int k = 0; k < 3; k++) begin
      cyc(8'h00, 1'b0);
      chk("drop_hold", grant, 8'h08);
    end
    cyc(8'h00, 1'b1);
    chk("drop_ack", grant, 8'h00);
    chk("drop_valid", {7'b0, grant_valid}, 8'h00);

    // 6. async reset mid-grant
    cyc(8'h20, 1'b0);
    chk("pre_reset", grant, 8'h20);
    rst_n = 1'b0;
    #1;
    chk("async_reset", grant, 8'h00);
    chk("async_valid", {7'b0, grant_valid}, 8'h00);
    req = 8'h00;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(8'h00, 1'b0);
    chk("post_reset", grant, 8'h00);

`ifdef RR_LOCK_EN
    cyc(8'hFF, 1'b0);
    chk("lock_first", grant, 8'h01);
    lock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(8'hFF, 1'b1);
      chk("lock_hold", grant, 8'h01);
    end
    lock = 1'b0;
    cyc(8'hFF, 1'b1);
    chk("lock_release", grant, 8'h02);
`endif

    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
